// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: shared constants and state encoding for the UART command sequencer
package uart_cmd_pkg;
  localparam logic [7:0] SYNC_BYTE   = 8'hA5;
  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_LEN     = 3'd1;
  localparam logic [2:0] ERR_CHK     = 3'd2;
  localparam logic [2:0] ERR_OVERRUN = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT = 3'd4;
  localparam logic [2:0] ERR_FRAME   = 3'd5;
  typedef enum logic [2:0] {S_IDLE, S_OPC, S_LEN, S_PAY, S_CHK, S_CMD, S_STREAM} state_t;
endpackage

// File: rtl/uart_cmd_buf.sv
// uart_cmd_buf: payload register file, one synchronous write port, one combinational read port
module uart_cmd_buf #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);
  logic [7:0] mem [DEPTH];
  always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/uart_cmd_sequencer.sv
// uart_cmd_sequencer: frames, checks, buffers and hands off UART commands to the SPI side
module uart_cmd_sequencer
  import uart_cmd_pkg::*;
#(
  parameter int MAX_LEN       = 8,
  parameter int TIMEOUT_TICKS = 320
) (
  input  logic       clk_8x,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       rx_frame_err,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic [7:0] cmd_opcode,
  output logic [3:0] cmd_len,
  output logic       pl_valid,
  input  logic       pl_ready,
  output logic [7:0] pl_data,
  output logic       pl_last,
  output logic       err_pulse,
  output logic [2:0] err_code,
  output logic [7:0] pkt_ok_cnt,
  output logic [7:0] pkt_err_cnt
);
  localparam int IW = $clog2(MAX_LEN + 1);
  localparam int BW = MAX_LEN > 1 ? $clog2(MAX_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);
  state_t state, state_n;
  logic [IW-1:0] idx;
  logic [TW-1:0] tcnt;
  logic [7:0] chk, rd;
  logic rx_st, byte_in, last, wr, err_n, ok_inc, bad_inc;
  logic [2:0] code_n;
  uart_cmd_buf #(.DEPTH(MAX_LEN), .AW(BW)) u_buf (
    .clk(clk_8x),
    .we(wr),
    .waddr(idx[BW-1:0]),
    .wdata(rx_data),
    .raddr(idx[BW-1:0]),
    .rdata(rd)
  );
  assign rx_st = state inside {S_OPC, S_LEN, S_PAY, S_CHK};
  assign byte_in = rx_valid && !rx_frame_err;
  assign last = 4'(idx) == cmd_len - 4'd1;
  assign cmd_valid = state == S_CMD;
  assign pl_valid = state == S_STREAM;
  assign pl_data = pl_valid ? rd : 8'd0;
  assign pl_last = pl_valid && last;
  always_comb begin
    state_n = state;
    wr = 1'b0;
    err_n = 1'b0;
    code_n = ERR_NONE;
    ok_inc = 1'b0;
    bad_inc = 1'b0;
    if (rx_st && rx_frame_err) begin
      state_n = S_IDLE;
      err_n = 1'b1;
      code_n = ERR_FRAME;
      bad_inc = 1'b1;
    end else if (rx_st && !rx_valid && tcnt == TW'(TIMEOUT_TICKS - 1)) begin
      state_n = S_IDLE;
      err_n = 1'b1;
      code_n = ERR_TIMEOUT;
      bad_inc = 1'b1;
    end else begin
      case (state)
        S_IDLE: state_n = byte_in && rx_data == SYNC_BYTE ? S_OPC : S_IDLE;
        S_OPC: state_n = byte_in ? S_LEN : S_OPC;
        S_LEN: if (byte_in) begin
          err_n = rx_data > 8'(MAX_LEN);
          code_n = err_n ? ERR_LEN : ERR_NONE;
          bad_inc = err_n;
          state_n = err_n ? S_IDLE : rx_data == 8'd0 ? S_CHK : S_PAY;
        end
        S_PAY: begin
          wr = byte_in;
          state_n = byte_in && last ? S_CHK : S_PAY;
        end
        S_CHK: if (byte_in) begin
          err_n = rx_data != chk;
          code_n = err_n ? ERR_CHK : ERR_NONE;
          bad_inc = err_n;
          ok_inc = !err_n;
          state_n = err_n ? S_IDLE : S_CMD;
        end
        S_CMD: begin
          state_n = cmd_ready ? (cmd_len == 4'd0 ? S_IDLE : S_STREAM) : S_CMD;
          err_n = rx_valid;
          code_n = rx_valid ? ERR_OVERRUN : ERR_NONE;
        end
        S_STREAM: begin
          state_n = pl_ready && last ? S_IDLE : S_STREAM;
          err_n = rx_valid;
          code_n = rx_valid ? ERR_OVERRUN : ERR_NONE;
        end
        default: state_n = S_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk_8x) state <= rst ? S_IDLE : state_n;
  always_ff @(posedge clk_8x) begin
    if (rst) begin
      idx <= '0;
      tcnt <= '0;
      chk <= '0;
      cmd_opcode <= '0;
      cmd_len <= '0;
      err_pulse <= 1'b0;
      err_code <= ERR_NONE;
      pkt_ok_cnt <= '0;
      pkt_err_cnt <= '0;
    end else begin
      tcnt <= rx_st && !rx_valid ? tcnt + TW'(1) : '0;
      idx <= state_n != state ? '0 : idx + IW'(wr || (pl_valid && pl_ready));
      err_pulse <= err_n;
      err_code <= err_n ? code_n : err_code;
      cmd_opcode <= state == S_OPC && byte_in ? rx_data : cmd_opcode;
      cmd_len <= state == S_LEN && byte_in ? rx_data[3:0] : cmd_len;
      chk <= !(rx_st && byte_in) ? chk : state == S_OPC ? rx_data : chk ^ rx_data;
      pkt_ok_cnt <= pkt_ok_cnt + 8'(ok_inc && pkt_ok_cnt != 8'hFF);
      pkt_err_cnt <= pkt_err_cnt + 8'(bad_inc && pkt_err_cnt != 8'hFF);
    end
  end
endmodule
